// File: rtl/conv2_window_gen_if.sv
// Pixel bus between the feature-map producer, the window serializer and conv2.
// The master side drives input pixels and the weight-loaded flag. The slave
// side (the serializer) returns the ready flag and the window pixel stream.
interface conv2_window_gen_if;
   logic               i_valid;
   logic signed [15:0] i_ch0;
   logic signed [15:0] i_ch1;
   logic signed [15:0] i_ch2;
   logic               i_weight_done;
   logic               o_ready;
   logic               o_valid;
   logic signed [15:0] o_ch0;
   logic signed [15:0] o_ch1;
   logic signed [15:0] o_ch2;
   logic               o_frame_done;

   modport master (
      output i_valid, i_ch0, i_ch1, i_ch2, i_weight_done,
      input  o_ready, o_valid, o_ch0, o_ch1, o_ch2, o_frame_done
   );

   modport slave (
      input  i_valid, i_ch0, i_ch1, i_ch2, i_weight_done,
      output o_ready, o_valid, o_ch0, o_ch1, o_ch2, o_frame_done
   );
endinterface

// File: rtl/conv2_window_gen.sv
// Window serializer for conv2. It buffers one raster-order 3-channel feature map.
// Once the conv2 weights are loaded, it emits every KxK window one pixel per
// cycle, with taps in ky*K+kx order.
module conv2_window_gen #(
   parameter int IMG_W = 14,
   parameter int IMG_H = 14,
   parameter int K     = 5
) (
   input logic                i_clk,
   input logic                i_rst,
   conv2_window_gen_if.slave  bus
);

   localparam int OW   = IMG_W - K + 1;
   localparam int OH   = IMG_H - K + 1;
   localparam int NPIX = IMG_W * IMG_H;
   localparam int AW   = (NPIX > 1) ? $clog2(NPIX) : 1;
   localparam int RW   = (OH > 1) ? $clog2(OH) : 1;
   localparam int CW   = (OW > 1) ? $clog2(OW) : 1;
   localparam int KW   = (K > 1) ? $clog2(K) : 1;

   localparam logic [AW-1:0] LAST_IDX = AW'(NPIX - 1);
   localparam logic [RW-1:0] R_MAX    = RW'(OH - 1);
   localparam logic [CW-1:0] C_MAX    = CW'(OW - 1);
   localparam logic [KW-1:0] K_MAX    = KW'(K - 1);

   typedef enum logic [1:0] {
      ST_LOAD,
      ST_WAIT,
      ST_STREAM
   } state_t;

   state_t          state_q, state_d;
   logic [AW-1:0]   load_idx_q;
   logic [RW-1:0]   r_q;
   logic [CW-1:0]   c_q;
   logic [KW-1:0]   ky_q;
   logic [KW-1:0]   kx_q;

   logic            load_we;
   logic            start;
   logic            issue;
   logic            last_issue;
   logic            ready;
   logic [AW-1:0]   rd_addr;

   logic signed [15:0] mem0 [0:NPIX-1];
   logic signed [15:0] mem1 [0:NPIX-1];
   logic signed [15:0] mem2 [0:NPIX-1];

   // Top-left corner of the window plus the tap offset, flattened to raster order.
   assign rd_addr = AW'((int'(r_q) + int'(ky_q)) * IMG_W + int'(c_q) + int'(kx_q));

   assign bus.o_ready = ready;

   // State register.
   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge i_clk) begin
      if (!i_rst) state_q <= ST_LOAD;
      else        state_q <= state_d;
   end

   // Next-state decode and per-cycle control strobes.
   // NOTE: every signal gets a default first so no path leaves one unassigned (no latches).
   always_comb begin
      state_d    = state_q;
      ready      = 1'b0;
      load_we    = 1'b0;
      start      = 1'b0;
      issue      = 1'b0;
      last_issue = 1'b0;
      case (state_q)
         ST_LOAD: begin
            ready = 1'b1;
            if (bus.i_valid) begin
               load_we = 1'b1;
               if (load_idx_q == LAST_IDX) state_d = ST_WAIT;
            end
         end
         ST_WAIT: begin
            if (bus.i_weight_done) begin
               start   = 1'b1;
               state_d = ST_STREAM;
            end
         end
         ST_STREAM: begin
            issue = 1'b1;
            if (r_q == R_MAX && c_q == C_MAX && ky_q == K_MAX && kx_q == K_MAX) begin
               last_issue = 1'b1;
               state_d    = ST_LOAD;
            end
         end
         default: state_d = ST_LOAD;
      endcase
   end

   // Load index and window walk counters: kx fastest, then ky, c, r.
   always_ff @(posedge i_clk) begin
      if (!i_rst) begin
         load_idx_q <= '0;
         r_q        <= '0;
         c_q        <= '0;
         ky_q       <= '0;
         kx_q       <= '0;
      end else begin
         if (load_we) begin
            load_idx_q <= (load_idx_q == LAST_IDX) ? '0 : load_idx_q + 1'b1;
         end
         if (start) begin
            r_q  <= '0;
            c_q  <= '0;
            ky_q <= '0;
            kx_q <= '0;
         end else if (issue) begin
            if (kx_q == K_MAX) begin
               kx_q <= '0;
               if (ky_q == K_MAX) begin
                  ky_q <= '0;
                  if (c_q == C_MAX) begin
                     c_q <= '0;
                     r_q <= (r_q == R_MAX) ? '0 : r_q + 1'b1;
                  end else begin
                     c_q <= c_q + 1'b1;
                  end
               end else begin
                  ky_q <= ky_q + 1'b1;
               end
            end else begin
               kx_q <= kx_q + 1'b1;
            end
         end
      end
   end

   // Feature-map storage write port.
   // NOTE: the pixel arrays have no reset; every entry is rewritten by a full load before it is read.
   always_ff @(posedge i_clk) begin
      if (i_rst && load_we) begin
         mem0[load_idx_q] <= bus.i_ch0;
         mem1[load_idx_q] <= bus.i_ch1;
         mem2[load_idx_q] <= bus.i_ch2;
      end
   end

   // Registered read port: one cycle of latency. Pixel outputs hold between beats.
   always_ff @(posedge i_clk) begin
      if (!i_rst) begin
         bus.o_valid      <= 1'b0;
         bus.o_frame_done <= 1'b0;
         bus.o_ch0        <= '0;
         bus.o_ch1        <= '0;
         bus.o_ch2        <= '0;
      end else begin
         bus.o_valid      <= issue;
         bus.o_frame_done <= last_issue;
         if (issue) begin
            bus.o_ch0 <= mem0[rd_addr];
            bus.o_ch1 <= mem1[rd_addr];
            bus.o_ch2 <= mem2[rd_addr];
         end
      end
   end

endmodule
